// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned words and applies controller redirects.
module ifetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   fifo_rd;
    logic [AW-1:0]   fifo_wr;
    logic [AW-1:0]   pq_rd;
    logic [AW-1:0]   pq_wr;

    logic [XLEN-1:0] fifo_data [BUF_DEPTH];
    logic [XLEN-1:0] fifo_pc   [BUF_DEPTH];
    logic [XLEN-1:0] pq        [BUF_DEPTH];

    logic [CW:0]     credit_use;
    logic            accept;
    logic            rsp_live;
    logic            push;
    logic            pop;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   drop_next;
    logic [XLEN-1:0] target;

    // Outstanding requests plus buffered words never exceed the FIFO depth,
    // so every response in RUN is guaranteed a slot.
    assign credit_use     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = (state == RUN) && (credit_use < {1'b0, DEPTH_C});
    assign imem_req_addr  = fetch_pc;

    assign accept    = imem_req_valid && imem_req_ready;
    assign rsp_live  = imem_rsp_valid && (state == RUN) && (outstanding != '0);
    assign push      = rsp_live && !redirect;
    assign pop       = instr_valid && instr_ready;
    assign out_next  = outstanding + CW'(accept) - CW'(rsp_live);
    assign drop_next = drop_cnt - CW'(imem_rsp_valid && (drop_cnt != '0));
    assign target    = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (redirect) begin
                        // Anything still in flight, including a request accepted
                        // this cycle, is stale and must be dropped on return.
                        fetch_pc    <= target;
                        outstanding <= '0;
                        drop_cnt    <= out_next;
                        fifo_count  <= '0;
                        fifo_rd     <= '0;
                        fifo_wr     <= '0;
                        pq_rd       <= '0;
                        pq_wr       <= '0;
                        state       <= (out_next != '0) ? FLUSH : RUN;
                    end else begin
                        if (accept) begin
                            fetch_pc <= fetch_pc + XLEN'(4);
                            pq_wr    <= pq_wr + 1'b1;
                        end
                        if (push) begin
                            fifo_wr <= fifo_wr + 1'b1;
                            pq_rd   <= pq_rd + 1'b1;
                        end
                        if (pop) begin
                            fifo_rd <= fifo_rd + 1'b1;
                        end
                        outstanding <= out_next;
                        fifo_count  <= fifo_count + CW'(push) - CW'(pop);
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    drop_cnt <= drop_next;
                    if (drop_next == '0) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pq[pq_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_data[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]   <= pq[pq_rd];
        end
    end

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? fifo_data[fifo_rd] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[fifo_rd] : '0;
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];

    assert property (@(posedge clk) disable iff (!rst_n) !(push && (fifo_count == DEPTH_C)));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding == '0) && (drop_cnt == '0)));

endmodule
